// File: rtl/cdp1802_cycle_sched.sv
`default_nettype none
// ============================================================================
// Module      : cdp1802_cycle_sched
// Description : CDP1802 machine-cycle scheduler. Generates the TPA/TPB pulses
//               and the state code, and arbitrates fetch/execute, DMA and
//               interrupt cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cdp1802_cycle_sched #(
    parameter int CYC_CLKS = 8,
    parameter int TPA_PH   = 1,
    parameter int TPB_PH   = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       exec_req,
    input  logic       exec_more,
    input  logic       idle,
    input  logic       ie,
    input  logic       dma_in_n,
    input  logic       dma_out_n,
    input  logic       int_n,
    output logic       TPA,
    output logic       TPB,
    output logic [1:0] SC,
    output logic [3:0] phase,
    output logic       cyc_end,
    output logic       dma_in_ack,
    output logic       dma_out_ack,
    output logic       int_ack
);

    localparam logic [3:0] c_LAST_PH = 4'(CYC_CLKS - 1);
    localparam logic [3:0] c_TPA_PH  = 4'(TPA_PH);
    localparam logic [3:0] c_TPB_PH  = 4'(TPB_PH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_DMA   = 2'b10,
        ST_INT   = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_sel_in;
    logic       w_sel_out;
    logic [3:0] r_phase;
    logic [3:0] w_phase_nxt;
    logic       w_last;
    logic       r_tpa;
    logic       r_tpb;
    logic       r_cyc_end;
    logic       r_dma_in_ack;
    logic       r_dma_out_ack;
    logic       r_int_ack;

    assign w_last      = (r_phase == c_LAST_PH);
    assign w_phase_nxt = w_last ? 4'd0 : r_phase + 4'd1;

    // Next cycle type; only consumed on the tick that closes the current cycle.
    always_comb begin
        w_state_nxt = ST_FETCH;
        w_sel_in    = 1'b0;
        w_sel_out   = 1'b0;
        if (r_state == ST_FETCH) begin
            w_state_nxt = exec_req ? ST_EXEC : ST_FETCH;
        end else if (r_state == ST_EXEC && exec_more) begin
            w_state_nxt = ST_EXEC;
        end else if (!dma_in_n) begin
            w_state_nxt = ST_DMA;
            w_sel_in    = 1'b1;
        end else if (!dma_out_n) begin
            w_state_nxt = ST_DMA;
            w_sel_out   = 1'b1;
        end else if (!int_n && ie && r_state != ST_INT) begin
            w_state_nxt = ST_INT;
        end else if (idle && r_state == ST_EXEC) begin
            w_state_nxt = ST_EXEC;
        end else begin
            w_state_nxt = ST_FETCH;
        end
    end

    // Pulses are registered on the tick that enters their phase, so they
    // line up with the phase value the outside world sees.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_FETCH;
            r_phase       <= 4'd0;
            r_tpa         <= 1'b0;
            r_tpb         <= 1'b0;
            r_cyc_end     <= 1'b0;
            r_dma_in_ack  <= 1'b0;
            r_dma_out_ack <= 1'b0;
            r_int_ack     <= 1'b0;
        end else if (ce) begin
            r_phase   <= w_phase_nxt;
            r_tpa     <= (w_phase_nxt == c_TPA_PH);
            r_tpb     <= (w_phase_nxt == c_TPB_PH);
            r_cyc_end <= (w_phase_nxt == c_LAST_PH);
            r_int_ack <= (w_phase_nxt == c_LAST_PH) && (r_state == ST_INT);
            if (w_last) begin
                r_state       <= w_state_nxt;
                r_dma_in_ack  <= w_sel_in;
                r_dma_out_ack <= w_sel_out;
            end
        end else begin
            r_tpa     <= 1'b0;
            r_tpb     <= 1'b0;
            r_cyc_end <= 1'b0;
            r_int_ack <= 1'b0;
        end
    end

    assign TPA         = r_tpa;
    assign TPB         = r_tpb;
    assign SC          = r_state;
    assign phase       = r_phase;
    assign cyc_end     = r_cyc_end;
    assign dma_in_ack  = r_dma_in_ack;
    assign dma_out_ack = r_dma_out_ack;
    assign int_ack     = r_int_ack;

endmodule
`default_nettype wire

// File: tb/tb_cdp1802_cycle_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdp1802_cycle_sched
// Description : Scoreboard bench for the 1802 machine-cycle scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdp1802_cycle_sched;

    logic       clock;
    logic       reset;
    logic       ce;
    logic       exec_req;
    logic       exec_more;
    logic       idle;
    logic       ie;
    logic       dma_in_n;
    logic       dma_out_n;
    logic       int_n;
    logic       TPA;
    logic       TPB;
    logic [1:0] SC;
    logic [3:0] phase;
    logic       cyc_end;
    logic       dma_in_ack;
    logic       dma_out_ack;
    logic       int_ack;

    cdp1802_cycle_sched #(.CYC_CLKS(8), .TPA_PH(1), .TPB_PH(6)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .ce          (ce),
        .exec_req    (exec_req),
        .exec_more   (exec_more),
        .idle        (idle),
        .ie          (ie),
        .dma_in_n    (dma_in_n),
        .dma_out_n   (dma_out_n),
        .int_n       (int_n),
        .TPA         (TPA),
        .TPB         (TPB),
        .SC          (SC),
        .phase       (phase),
        .cyc_end     (cyc_end),
        .dma_in_ack  (dma_in_ack),
        .dma_out_ack (dma_out_ack),
        .int_ack     (int_ack)
    );

    typedef struct packed {
        logic [1:0] sc;
        logic       din;
        logic       dout;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mon_t    = 0;
    bit   mon_en   = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: tracks its own tick count within the cycle and pops the
    // expected cycle type at every cycle boundary.
    always @(negedge clock) begin
        if (mon_en) begin
            if (mon_t == 7) begin
                mon_t = 0;
                if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
                else cur = sb.pop_front();
            end else begin
                mon_t++;
            end
            chk("sc",      32'(SC),          32'(cur.sc));
            chk("phase",   32'(phase),       32'(mon_t));
            chk("tpa",     32'(TPA),         32'(mon_t == 1));
            chk("tpb",     32'(TPB),         32'(mon_t == 6));
            chk("cyc_end", 32'(cyc_end),     32'(mon_t == 7));
            chk("din_ack", 32'(dma_in_ack),  32'(cur.din));
            chk("dout_ack",32'(dma_out_ack), 32'(cur.dout));
            chk("int_ack", 32'(int_ack),     32'(mon_t == 7 && cur.sc == 2'b11));
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        #2 reset = 1'b1;
        ce = 1'b1; exec_req = 1'b0; exec_more = 1'b0; idle = 1'b0; ie = 1'b0;
        dma_in_n = 1'b1; dma_out_n = 1'b1; int_n = 1'b1;
        #1 chk("reset_outs", 32'({TPA, TPB, SC, phase, cyc_end, dma_in_ack, dma_out_ack, int_ack}), 32'd0);
        sb.delete();
        @(negedge clock);
        #1 reset = 1'b0;
        chk("rel_sc", 32'(SC), 32'd0);
        chk("rel_phase", 32'(phase), 32'd0);
        mon_t  = 0;
        cur    = '{2'b00, 1'b0, 1'b0};
        mon_en = 1'b1;
    endtask

    // Apply inputs at the closing tick of the current cycle and record the
    // cycle type they must produce next.
    task automatic decide(input bit er, input bit em, input bit idl, input bit ien,
                          input bit din_n, input bit dout_n, input bit in_n,
                          input logic [1:0] esc, input bit ein, input bit eout);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cyc_end && n < 20);
        if (!cyc_end) chk("cyc_end_timeout", 32'd0, 32'd1);
        exec_req = er; exec_more = em; idle = idl; ie = ien;
        dma_in_n = din_n; dma_out_n = dout_n; int_n = in_n;
        sb.push_back('{esc, ein, eout});
    endtask

    initial begin
        int n;
        int tpa_cnt;
        int tpb_cnt;
        bit seen;
        reset = 1'b1;
        do_reset();

        // Reset aborting an execute cycle in phase 3
        decide(1,0,0,0,1,1,1, 2'b01,0,0);
        repeat (4) @(negedge clock);
        chk("pre_reset_phase", 32'(phase), 32'd3);
        chk("pre_reset_sc",    32'(SC),    32'd1);
        do_reset();

        // Plain fetch/execute alternation
        decide(1,0,0,0,1,1,1, 2'b01,0,0);
        decide(1,0,0,0,1,1,1, 2'b00,0,0);
        decide(1,0,0,0,1,1,1, 2'b01,0,0);
        decide(1,0,0,0,1,1,1, 2'b00,0,0);

        // Clock enable toggling: one machine cycle spans 16 clocks
        mon_en = 1'b0;
        ce = 1'b0; n = 0; tpa_cnt = 0; tpb_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            n++;
            if (TPA) tpa_cnt++;
            if (TPB) tpb_cnt++;
            if (cyc_end) seen = 1'b1;
            else ce = ~ce;
        end
        chk("ce_cycle_clocks", 32'(n), 32'd16);
        chk("ce_tpa_count", 32'(tpa_cnt), 32'd1);
        chk("ce_tpb_count", 32'(tpb_cnt), 32'd1);
        do_reset();

        // Eight back-to-back DMA-out cycles after S1
        decide(1,0,0,0,1,1,1, 2'b01,0,0);
        for (int k = 0; k < 8; k++) decide(0,0,0,0,1,0,1, 2'b10,0,1);
        decide(0,0,0,0,1,1,1, 2'b00,0,0);
        // DMA-out raised during S0 waits for the following S1
        decide(1,0,0,0,1,0,1, 2'b01,0,0);
        decide(0,0,0,0,1,0,1, 2'b10,0,1);
        decide(0,0,0,0,1,1,1, 2'b00,0,0);

        // Interrupt with ie=1, then held request with ie=0
        decide(1,0,0,1,1,1,1, 2'b01,0,0);
        decide(0,0,0,1,1,1,0, 2'b11,0,0);
        decide(0,0,0,0,1,1,0, 2'b00,0,0);
        decide(1,0,0,0,1,1,0, 2'b01,0,0);
        decide(0,0,0,0,1,1,0, 2'b00,0,0);

        // Simultaneous DMA-in, DMA-out and INT
        decide(1,0,0,1,1,1,1, 2'b01,0,0);
        decide(0,0,0,1,0,0,0, 2'b10,1,0);
        decide(0,0,0,1,1,0,0, 2'b10,0,1);
        decide(0,0,0,1,1,1,0, 2'b11,0,0);
        decide(0,0,0,0,1,1,1, 2'b00,0,0);

        // Idle loop broken by an interrupt; no return to idle afterwards
        decide(1,0,0,0,1,1,1, 2'b01,0,0);
        for (int k = 0; k < 3; k++) decide(0,0,1,1,1,1,1, 2'b01,0,0);
        decide(0,0,1,1,1,1,0, 2'b11,0,0);
        decide(0,0,1,0,1,1,1, 2'b00,0,0);

        // Long instruction beats a pending DMA-out
        decide(1,0,0,0,1,1,1, 2'b01,0,0);
        decide(0,1,0,0,1,0,1, 2'b01,0,0);
        decide(0,0,0,0,1,0,1, 2'b10,0,1);
        decide(0,0,0,0,1,1,1, 2'b00,0,0);
        decide(0,0,0,0,1,1,1, 2'b00,0,0);

        @(negedge clock);
        @(negedge clock);
        #1 mon_en = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
